// File: rtl/cnn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cnn_pkg: pooling geometry and window element indices                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cnn_pkg;

   localparam int POOL_K      = 2;
   localparam int POOL_STRIDE = 2;
   localparam int POOL_LEN    = POOL_K * POOL_K;

   // Element slots inside a packed window, shared with the max reducer.
   localparam int TL = 0;
   localparam int TR = 1;
   localparam int BL = 2;
   localparam int BR = 3;

   localparam int PIXEL_W = 8;
   typedef logic signed [PIXEL_W-1:0] pixel_t;

endpackage
`default_nettype wire

// File: rtl/pool_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pool_line_buffer: one-row store, one write port, two async reads     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pool_line_buffer #(
   parameter int DEPTH = 28,
   parameter int WIDTH = 8,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr0,
   output logic [WIDTH-1:0] o_rdata0,
   input  logic [AW-1:0]    i_raddr1,
   output logic [WIDTH-1:0] o_rdata1
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata0 = r_mem[i_raddr0];
   assign o_rdata1 = r_mem[i_raddr1];

endmodule
`default_nettype wire

// File: rtl/pool_window_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pool_window_gen: raster pixel stream -> packed 2x2 stride-2 windows  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pool_window_gen
   import cnn_pkg::*;
#(
   parameter int BITWIDTH = 8,
   parameter int IMG_W    = 28,
   parameter int IMG_H    = 28
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [BITWIDTH-1:0]          in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [POOL_LEN*BITWIDTH-1:0] out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_last
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] c_COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] c_ROW_LAST = RW'(IMG_H - 1);

   if (IMG_W < 2 || (IMG_W % 2) != 0) begin : g_bad_img_w
      $error("pool_window_gen: IMG_W must be even and >= 2");
   end
   if (IMG_H < 2 || (IMG_H % 2) != 0) begin : g_bad_img_h
      $error("pool_window_gen: IMG_H must be even and >= 2");
   end

   logic [CW-1:0]                r_col;
   logic [RW-1:0]                r_row;
   logic [BITWIDTH-1:0]          r_hold;
   logic [POOL_LEN*BITWIDTH-1:0] r_out_data;
   logic                         r_out_valid;
   logic                         r_out_last;

   logic                w_accept;
   logic                w_emit;
   logic                w_col_end;
   logic                w_frame_end;
   logic [CW-1:0]       w_addr_left;
   logic [BITWIDTH-1:0] w_top_left;
   logic [BITWIDTH-1:0] w_top_right;

   assign in_ready    = !r_out_valid || out_ready;
   assign w_accept    = in_valid && in_ready;
   assign w_col_end   = (r_col == c_COL_LAST);
   assign w_frame_end = w_col_end && (r_row == c_ROW_LAST);
   // Bottom-right pixel of a window: odd row, odd column.
   assign w_emit      = w_accept && r_row[0] && r_col[0];
   assign w_addr_left = r_col - 1'b1;

   pool_line_buffer #(
      .DEPTH (IMG_W),
      .WIDTH (BITWIDTH),
      .AW    (CW)
   ) u_line_buffer (
      .clk      (clk),
      .i_we     (w_accept && !r_row[0]),
      .i_waddr  (r_col),
      .i_wdata  (in_data),
      .i_raddr0 (w_addr_left),
      .o_rdata0 (w_top_left),
      .i_raddr1 (r_col),
      .o_rdata1 (w_top_right)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_col       <= '0;
         r_row       <= '0;
         r_hold      <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else begin
         if (w_accept) begin
            if (w_col_end) begin
               r_col <= '0;
               r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
            if (r_row[0] && !r_col[0]) begin
               r_hold <= in_data;
            end
         end
         // A fresh window wins over a concurrent consume, so no bubble.
         if (w_emit) begin
            r_out_data[TL*BITWIDTH +: BITWIDTH] <= w_top_left;
            r_out_data[TR*BITWIDTH +: BITWIDTH] <= w_top_right;
            r_out_data[BL*BITWIDTH +: BITWIDTH] <= r_hold;
            r_out_data[BR*BITWIDTH +: BITWIDTH] <= in_data;
            r_out_valid                         <= 1'b1;
            r_out_last                          <= w_frame_end;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_pool_window_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pool_window_gen: random/directed stimulus vs frame-array model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pool_window_gen;
   import cnn_pkg::*;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int BW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [BW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [4*BW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;

   always #5 clk = ~clk;

   pool_window_gen #(.BITWIDTH(BW), .IMG_W(W), .IMG_H(H)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Reference model: image array filled in raster order, windows cut from it.
   logic [BW-1:0] img [H][W];
   int            pos = 0;
   logic [32:0]   exp_q[$];
   logic [32:0]   obs_q[$];
   bit            chk_rst = 0, chk_new = 0, chk_hold = 0, mon_on = 0;
   logic [32:0]   new_exp, held;

   always @(negedge clk) begin
      if (mon_on) begin
         check_eq("in_ready", in_ready, !out_valid || out_ready);
         if (!rst_n) begin
            exp_q.delete();
            pos = 0; chk_rst = 1; chk_new = 0; chk_hold = 0;
         end else begin
            if (chk_rst) check_eq("valid_after_reset", out_valid, 1'b0);
            chk_rst = 0;
            if (chk_hold) check_eq("hold", {out_valid, out_last, out_data}, {1'b1, held});
            if (chk_new) check_eq("latency", {out_valid, out_last, out_data}, {1'b1, new_exp});
            if (out_valid) begin
               if (exp_q.size() == 0) check_eq("spurious_valid", out_valid, 1'b0);
               else if (out_ready) begin
                  logic [32:0] e;
                  e = exp_q.pop_front();
                  check_eq("window", {out_last, out_data}, e);
                  obs_q.push_back({out_last, out_data});
               end
            end
            chk_hold = out_valid && !out_ready;
            held     = {out_last, out_data};
            chk_new  = 0;
            if (in_valid && in_ready) begin
               int r, c;
               r = pos / W; c = pos % W;
               img[r][c] = in_data;
               if ((r % 2) == 1 && (c % 2) == 1) begin
                  new_exp = {(pos == W*H-1), img[r][c], img[r][c-1], img[r-1][c], img[r-1][c-1]};
                  exp_q.push_back(new_exp);
                  chk_new = 1;
               end
               pos = (pos + 1) % (W*H);
            end
         end
      end
   end

   // Consumer: 0 = always ready, 1 = random, 2 = stall 3 cycles on first window.
   int rdy_mode = 0;
   int stall_left = 0;
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            1: out_ready = 1'($urandom_range(0, 1));
            2: if (out_valid && stall_left > 0) begin out_ready = 1'b0; stall_left--; end
               else out_ready = 1'b1;
            default: out_ready = 1'b1;
         endcase
      end
   end

   task automatic send_pixel(input logic [BW-1:0] v, input bit gap);
      int n;
      in_data = v; in_valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!in_ready && n < 200);
      if (!in_ready) check_eq("accept_timeout", n, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (gap) begin @(posedge clk); #1; end
   endtask

   task automatic send_frame_seq(input bit gap);
      for (int i = 0; i < W*H; i++) send_pixel(BW'(i), gap);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 100) begin @(posedge clk); #1; n++; end
      check_eq("drain", exp_q.size(), 0);
   endtask

   logic [31:0] basic_exp [4] = '{32'h05040100, 32'h07060302, 32'h0D0C0908, 32'h0F0E0B0A};

   task automatic check_basic(input string tag);
      check_eq({tag, "_count"}, obs_q.size(), 4);
      for (int i = 0; i < 4 && i < obs_q.size(); i++)
         check_eq(tag, obs_q[i], {(i == 3), basic_exp[i]});
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
      mon_on = 1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_eq("reset_state", {out_valid, out_last, out_data, in_ready}, {2'b00, 32'h0, 1'b1});
      @(posedge clk); #1;

      obs_q.delete(); rdy_mode = 0;
      send_frame_seq(0); drain(); check_basic("basic");

      obs_q.delete(); rdy_mode = 2; stall_left = 3;
      send_frame_seq(0); drain(); check_basic("backpressure");
      rdy_mode = 0;

      obs_q.delete();
      send_pixel(8'h80, 0); send_pixel(8'h7F, 0);
      for (int i = 2; i < W; i++) send_pixel(BW'($urandom), 0);
      send_pixel(8'hFF, 0); send_pixel(8'h00, 0);
      for (int i = W + 2; i < W*H; i++) send_pixel(BW'($urandom), 0);
      drain();
      check_eq("signed_window", obs_q.size() > 0 ? obs_q[0][31:0] : 32'hX, 32'h00FF7F80);
      if (obs_q.size() > 0) begin
         pixel_t m, p;
         m = pixel_t'(obs_q[0][7:0]);
         for (int i = 1; i < 4; i++) begin
            p = pixel_t'(obs_q[0][8*i +: 8]);
            if (p > m) m = p;
         end
         check_eq("signed_max", 64'(m), 64'(pixel_t'(127)));
      end

      obs_q.delete();
      send_frame_seq(1); drain(); check_basic("gaps");

      for (int i = 0; i < 7; i++) send_pixel(BW'(i), 0);
      rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
      obs_q.delete();
      send_frame_seq(0); drain(); check_basic("mid_reset");

      obs_q.delete(); rdy_mode = 1;
      for (int i = 0; i < 2*W*H; i++) send_pixel(BW'($urandom), 0);
      drain();
      begin
         logic [7:0] lasts = '0;
         for (int i = 0; i < 8 && i < obs_q.size(); i++) lasts[i] = obs_q[i][32];
         check_eq("b2b_count", obs_q.size(), 8);
         check_eq("b2b_lasts", lasts, 8'b1000_1000);
      end

      obs_q.delete();
      for (int i = 0; i < 3*W*H; i++) send_pixel(BW'($urandom), 1'($urandom_range(0, 1)));
      drain();
      check_eq("random_count", obs_q.size(), 12);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pool_window_gen.md
Name: pool_window_gen

Overview:
- Streaming producer of 2x2, stride-2 pooling windows for the max-pool reducer.
- Accepts one signed feature-map pixel per handshake in raster order.
- Buffers the even rows internally.
- Emits each complete 2x2 window as one packed LENGTH=4 word whose element layout matches the reducer's data input, so the output connects to it with no glue.

Parameters:
- BITWIDTH, 8, pixel width in bits, two's-complement signed.
- IMG_W, 28, feature-map width in pixels. Must be even and >=2; elaboration error otherwise.
- IMG_H, 28, feature-map height in pixels. Must be even and >=2; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_data  input  BITWIDTH  pixel, signed.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a pixel this cycle.
- out_data  output  4*BITWIDTH  packed window. Element i is at [i*BITWIDTH +: BITWIDTH]: 0=top-left, 1=top-right, 2=bottom-left, 3=bottom-right.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- out_last  output  1  qualifies the final window of a frame.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-low: on the rising clk edge with rst_n=0, all state clears.
- Reset values: col=0, row=0, out_valid=0, out_last=0, out_data=0, hold register=0. Line-buffer contents are don't-care, with no reset requirement on the RAM.
- Input accept: a pixel is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready, so stalls propagate combinationally from out_ready. in_ready is 1 immediately after reset.
- Counters: col runs 0..IMG_W-1 and row runs 0..IMG_H-1. On each accept col increments. At col=IMG_W-1, col wraps to 0 and row increments. At row=IMG_H-1 and col=IMG_W-1, both wrap to 0 and the next frame starts with no idle cycle.
- Even row (row[0]=0): the accepted pixel is written to line buffer entry col. Nothing is emitted.
- Odd row, even col: the accepted pixel is stored in the hold register as bottom-left.
- Odd row, odd col: the window is registered into out_data and out_valid=1 on the next edge. The window is {linebuf[col-1], linebuf[col], hold, in_data} in element order 0..3.
- out_last: set together with that window when row=IMG_H-1 and col=IMG_W-1.
- Latency: the window is valid exactly 1 cycle after the bottom-right pixel is accepted.
- Output hold: out_valid, out_data and out_last stay stable until out_valid && out_ready.
- Output clear: if out_ready=1 and no new window is produced that cycle, out_valid clears on the next edge.
- Simultaneous events: consumer takes the current window while a new bottom-right pixel is accepted. The new window overwrites the register and out_valid stays 1, giving full throughput of one window per 4 pixels with no bubble.
- Data integrity: pixels pass through unmodified, with no arithmetic, saturation or sign change. Values -128 and 127 must survive bit-exact.
- Reset mid-frame: the partial frame is discarded and any pending window is dropped (out_valid=0). The next accepted pixel is treated as row 0, col 0.
- in_valid low: counters and buffers hold, with no spurious output.
- Line buffer: IMG_W x BITWIDTH storage. Read address col-1 and col in the same cycle as the bottom-right accept. Implement as a register array or a two-read-port RAM. Combinational reads are acceptable at these sizes.

Decomposition:
- Shared package (cnn_pkg), constants:
  - POOL_K=2
  - POOL_STRIDE=2
  - POOL_LEN=POOL_K*POOL_K
  - Element index constants TL=0, TR=1, BL=2, BR=3, shared with the reducer's instantiation.
- Typedef: pixel_t = signed [BITWIDTH-1:0].
- One natural sub-module: pool_line_buffer. Single write port and two asynchronous read ports, depth IMG_W, width BITWIDTH.
- Counters, hold register and output register stay in pool_window_gen.

Test Plan:
- Basic frame, IMG_W=4, IMG_H=4, pixels 0..15 streamed continuously, out_ready=1:
  - Four windows in order: 0x05040100, 0x07060302, 0x0D0C0908, 0x0F0E0B0A.
  - Each window appears 1 cycle after accepting pixel 5, 7, 13, 15 respectively.
  - out_last=1 only on 0x0F0E0B0A.
- Backpressure: out_ready=0 for 3 cycles while the first window is valid:
  - in_ready=0 during those cycles and out_data is held at 0x05040100.
  - No pixel is lost, and the remaining windows are identical to the basic case.
- Signed extremes: pixels row0 = {-128, 127, ...}, row1 = {-1, 0, ...}:
  - First window is 0x00FF7F80, bit-exact.
  - Feeding it to the max reducer yields 127.
- Input gaps: in_valid toggles 1/0 every cycle on the basic frame:
  - Same four windows, with no duplicates and no spurious out_valid.
- Reset mid-frame: rst_n=0 for 1 cycle after pixel 6, then a fresh frame of pixels 0..15:
  - out_valid=0 the cycle after reset.
  - The output is exactly the basic-frame sequence, with out_last only on the fourth window.
- Back-to-back frames: two frames sent with no idle cycle:
  - 8 windows, out_last on windows 4 and 8.
  - Second-frame windows are correct, with no stale line-buffer data.
